// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and request payload for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int unsigned LSB_CAP_BIT = 3;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_W       = 3;

    localparam logic [1:0] IO_SEL   = 2'b11;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        MEMC_IDLE  = 2'd0,
        MEMC_FETCH = 2'd1,
        MEMC_LOAD  = 2'd2,
        MEMC_STORE = 2'd3
    } memc_state_e;

    typedef struct packed {
        logic [LSB_CAP_BIT-1:0] pos;
        logic [ADDR_W-1:0]      addr;
        logic [DATA_W-1:0]      data;
        logic [CNT_W-1:0]       n;
    } mem_req_t;

    // Number of bus bytes for an access length; the reserved encoding is treated as a word.
    function automatic logic [CNT_W-1:0] len_to_n(input logic [1:0] len);
        case (len)
            LEN_BYTE: return CNT_W'(1);
            LEN_HALF: return CNT_W'(2);
            LEN_WORD: return CNT_W'(4);
            default:  return CNT_W'(4);
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[17:16] == IO_SEL;
    endfunction

    function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w, input logic [1:0] idx,
                                                   input logic [BYTE_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = w;
        r[{idx, 3'b000} +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller serving LSB loads/stores and instruction fetches, little-endian.
// Define MEM_IO_STALL_EN to hold IO-mapped store bytes while the UART buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear,
    input  logic                   io_buffer_full,
    input  logic                   lsb_req,
    input  logic [LSB_CAP_BIT-1:0] lsb_pos,
    input  logic                   lsb_ls,
    input  logic [1:0]             lsb_len,
    input  logic [ADDR_W-1:0]      lsb_addr,
    input  logic [DATA_W-1:0]      lsb_wdata,
    output logic                   lsb_finished,
    output logic [DATA_W-1:0]      lsb_rdata,
    output logic [LSB_CAP_BIT-1:0] lsb_pos_out,
    output logic                   mem_busy,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic                   if_ready,
    output logic [DATA_W-1:0]      if_inst,
    output logic                   inst_need_work,
    input  logic [BYTE_W-1:0]      mem_din,
    output logic [BYTE_W-1:0]      mem_dout,
    output logic [ADDR_W-1:0]      mem_a,
    output logic                   mem_wr
);

    memc_state_e            state_q, state_d;
    mem_req_t               req_q, req_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      rbuf_q, rbuf_d, rbuf_ins;
    logic                   squash_q, squash_d;
    logic [ADDR_W-1:0]      byte_addr, mem_a_d;
    logic [BYTE_W-1:0]      mem_dout_d;
    logic                   mem_wr_q, mem_wr_d;
    logic                   mem_busy_d;
    logic                   lsb_finished_d, if_ready_d;
    logic [DATA_W-1:0]      lsb_rdata_d, if_inst_d;
    logic [LSB_CAP_BIT-1:0] lsb_pos_d;
    logic                   rd_last;
    logic                   start_stall, byte_stall;

    assign inst_need_work = if_req && (state_q == MEMC_IDLE) && !if_ready;
    // A paused pipeline must never see a repeated write strobe.
    assign mem_wr    = mem_wr_q && rdy_in;
    assign byte_addr = req_q.addr + ADDR_W'(cnt_q);
    assign rbuf_ins  = put_byte(rbuf_q, cnt_q[1:0], mem_din);
    assign rd_last   = (cnt_q == req_q.n - CNT_W'(1));

`ifdef MEM_IO_STALL_EN
    assign start_stall = is_io(lsb_addr) && io_buffer_full;
    assign byte_stall  = is_io(byte_addr) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign start_stall    = 1'b0;
    assign byte_stall     = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        cnt_d          = cnt_q;
        rbuf_d         = rbuf_q;
        squash_d       = squash_q;
        mem_a_d        = mem_a;
        mem_dout_d     = mem_dout;
        mem_wr_d       = 1'b0;
        lsb_finished_d = 1'b0;
        lsb_rdata_d    = lsb_rdata;
        lsb_pos_d      = lsb_pos_out;
        if_ready_d     = 1'b0;
        if_inst_d      = if_inst;

        case (state_q)
            MEMC_IDLE: begin
                if (lsb_req && !clear) begin
                    req_d.pos  = lsb_pos;
                    req_d.addr = lsb_addr;
                    req_d.data = lsb_wdata;
                    req_d.n    = len_to_n(lsb_len);
                    cnt_d      = '0;
                    rbuf_d     = '0;
                    squash_d   = 1'b0;
                    mem_a_d    = lsb_addr;
                    if (lsb_ls) begin
                        state_d = MEMC_STORE;
                        if (!start_stall) begin
                            mem_dout_d = lsb_wdata[BYTE_W-1:0];
                            mem_wr_d   = 1'b1;
                            cnt_d      = CNT_W'(1);
                        end
                    end else begin
                        state_d = MEMC_LOAD;
                    end
                end else if (inst_need_work) begin
                    req_d.addr = if_addr;
                    req_d.n    = CNT_W'(4);
                    cnt_d      = '0;
                    rbuf_d     = '0;
                    mem_a_d    = if_addr;
                    state_d    = MEMC_FETCH;
                end
            end

            // Reads: cnt is the byte currently addressed; its data arrives by the next edge.
            MEMC_FETCH, MEMC_LOAD: begin
                if (clear) begin
                    state_d = MEMC_IDLE;
                end else if (rd_last) begin
                    state_d = MEMC_IDLE;
                    if (state_q == MEMC_FETCH) begin
                        if_ready_d = 1'b1;
                        if_inst_d  = rbuf_ins;
                    end else begin
                        lsb_finished_d = 1'b1;
                        lsb_rdata_d    = rbuf_ins;
                        lsb_pos_d      = req_q.pos;
                    end
                end else begin
                    rbuf_d  = rbuf_ins;
                    cnt_d   = cnt_q + CNT_W'(1);
                    mem_a_d = byte_addr + ADDR_W'(1);
                end
            end

            // Stores: cnt counts bytes already put on the bus; a flushed store still drains.
            MEMC_STORE: begin
                squash_d = squash_q || clear;
                if (cnt_q == req_q.n) begin
                    state_d = MEMC_IDLE;
                    if (!(squash_q || clear)) begin
                        lsb_finished_d = 1'b1;
                        lsb_pos_d      = req_q.pos;
                    end
                end else if (!byte_stall) begin
                    mem_a_d    = byte_addr;
                    mem_dout_d = get_byte(req_q.data, cnt_q[1:0]);
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = MEMC_IDLE;
        endcase

        mem_busy_d = (state_d != MEMC_IDLE);
    end

    // State register; a low rdy_in freezes every register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= MEMC_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            rbuf_q       <= '0;
            squash_q     <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= '0;
            mem_wr_q     <= 1'b0;
            mem_busy     <= 1'b0;
            lsb_finished <= 1'b0;
            lsb_rdata    <= '0;
            lsb_pos_out  <= '0;
            if_ready     <= 1'b0;
            if_inst      <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            rbuf_q       <= rbuf_d;
            squash_q     <= squash_d;
            mem_a        <= mem_a_d;
            mem_dout     <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            mem_busy     <= mem_busy_d;
            lsb_finished <= lsb_finished_d;
            lsb_rdata    <= lsb_rdata_d;
            lsb_pos_out  <= lsb_pos_d;
            if_ready     <= if_ready_d;
            if_inst      <= if_inst_d;
        end
    end

endmodule
